chip8_alu_sequencer: RTL and testbench

CHIP8_ALU_SEQUENCER -- requirements
Module: chip8_alu_sequencer

---
 rtl/chip8_alu_sequencer.sv | 171 +++++++++++++++++
 tb/tb_chip8_alu_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_alu_sequencer.sv
// Chip-8 8XYN ALU sequencer: reads VX/VY, drives an external ALU, writes VX
// and (for flag ops) VF back to the register file.
// Optional macro CHIP8_SHIFT_VY_EN: shifts (N=6, N=E) take their source from
// VY (COSMAC behaviour) instead of VX; the result always lands in VX.

package chip8_alu_pkg;
  typedef enum logic [2:0] {
    ALU_f_NOP    = 3'd0,
    ALU_f_OR     = 3'd1,
    ALU_f_AND    = 3'd2,
    ALU_f_XOR    = 3'd3,
    ALU_f_ADD    = 3'd4,
    ALU_f_MINUS  = 3'd5,
    ALU_f_RSHIFT = 3'd6,
    ALU_f_LSHIFT = 3'd7
  } alu_f_t;
endpackage

module chip8_alu_sequencer
  import chip8_alu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [15:0]  opcode,
  output logic         busy,
  output logic         done,
  output logic         illegal,
  output logic [3:0]   rd_addr_a,
  output logic [3:0]   rd_addr_b,
  input  logic [7:0]   rd_data_a,
  input  logic [7:0]   rd_data_b,
  output logic         wr_en,
  output logic [3:0]   wr_addr,
  output logic [7:0]   wr_data,
  output logic [15:0]  alu_in1,
  output logic [15:0]  alu_in2,
  output alu_f_t       alu_sel,
  input  logic [15:0]  alu_out
);

  typedef enum logic [2:0] {IDLE, READ, EXEC, WB_VX, WB_VF, DONE} state_t;

  state_t      state_reg, state_next;
  logic [11:0] opcode_reg;     // X, Y, N; the 8 prefix is known once legal
  logic [7:0]  result_reg;
  logic        flag_reg, flag_next;
  logic        illegal_reg;

  logic [3:0]  x_reg, y_reg, n_reg;
  logic        has_flag;
  logic [7:0]  shift_src;

  assign x_reg = opcode_reg[11:8];
  assign y_reg = opcode_reg[7:4];
  assign n_reg = opcode_reg[3:0];

  // Only ADD, SUB, SUBN and the two shifts produce a VF write.
  assign has_flag = (n_reg == 4'h4) || (n_reg == 4'h5) || (n_reg == 4'h6) ||
                    (n_reg == 4'h7) || (n_reg == 4'hE);

`ifdef CHIP8_SHIFT_VY_EN
  assign shift_src = rd_data_b;
`else
  assign shift_src = rd_data_a;
`endif

  function automatic logic is_legal(input logic [15:0] op);
    return (op[15:12] == 4'h8) && ((op[3:0] <= 4'h7) || (op[3:0] == 4'hE));
  endfunction

  // State register plus opcode latch on accept and result/flag capture in EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      opcode_reg  <= '0;
      result_reg  <= '0;
      flag_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        opcode_reg  <= opcode[11:0];
        illegal_reg <= !is_legal(opcode);
      end
      if (state_reg == EXEC) begin
        result_reg <= alu_out[7:0];
        flag_reg   <= flag_next;
      end
    end
  end

  // ALU operand/function mapping and flag extraction; ALU idles outside EXEC.
  always_comb begin
    alu_in1   = '0;
    alu_in2   = '0;
    alu_sel   = ALU_f_NOP;
    flag_next = 1'b0;
    if (state_reg == EXEC) begin
      unique case (n_reg)
        4'h0: begin alu_in1 = {8'h00, rd_data_b}; alu_sel = ALU_f_OR; end
        4'h1: begin alu_in1 = {8'h00, rd_data_a}; alu_in2 = {8'h00, rd_data_b}; alu_sel = ALU_f_OR;  end
        4'h2: begin alu_in1 = {8'h00, rd_data_a}; alu_in2 = {8'h00, rd_data_b}; alu_sel = ALU_f_AND; end
        4'h3: begin alu_in1 = {8'h00, rd_data_a}; alu_in2 = {8'h00, rd_data_b}; alu_sel = ALU_f_XOR; end
        4'h4: begin
          alu_in1 = {8'h00, rd_data_a}; alu_in2 = {8'h00, rd_data_b}; alu_sel = ALU_f_ADD;
          flag_next = alu_out[8];
        end
        4'h5: begin
          alu_in1 = {8'h00, rd_data_a}; alu_in2 = {8'h00, rd_data_b}; alu_sel = ALU_f_MINUS;
          flag_next = (alu_out[15:8] == 8'h00);
        end
        4'h7: begin
          alu_in1 = {8'h00, rd_data_b}; alu_in2 = {8'h00, rd_data_a}; alu_sel = ALU_f_MINUS;
          flag_next = (alu_out[15:8] == 8'h00);
        end
        4'h6: begin
          alu_in1 = {8'h00, shift_src}; alu_in2 = 16'd1; alu_sel = ALU_f_RSHIFT;
          flag_next = shift_src[0];
        end
        4'hE: begin
          alu_in1 = {8'h00, shift_src}; alu_in2 = 16'd1; alu_sel = ALU_f_LSHIFT;
          flag_next = shift_src[7];
        end
        default: begin end
      endcase
    end
  end

  // Next-state logic and register-file / handshake outputs.
  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != IDLE);
    done       = 1'b0;
    illegal    = 1'b0;
    rd_addr_a  = '0;
    rd_addr_b  = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    unique case (state_reg)
      IDLE:  if (start) state_next = is_legal(opcode) ? READ : DONE;
      READ: begin
        rd_addr_a  = x_reg;
        rd_addr_b  = y_reg;
        state_next = EXEC;
      end
      EXEC:  state_next = WB_VX;
      WB_VX: begin
        wr_en      = 1'b1;
        wr_addr    = x_reg;
        wr_data    = result_reg;
        state_next = has_flag ? WB_VF : DONE;
      end
      // Flag write comes last so VF holds the flag even when X=F.
      WB_VF: begin
        wr_en      = 1'b1;
        wr_addr    = 4'hF;
        wr_data    = {7'b0, flag_reg};
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        illegal    = illegal_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Randomized self-checking bench for chip8_alu_sequencer: a bench-side register
// file and ALU surround the DUT; a behavioural opcode model predicts writes,
// latency and final register contents.
module tb_chip8_alu_sequencer;
  import chip8_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] opcode;
  logic        busy, done, illegal;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [7:0]  rd_data_a, rd_data_b;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] alu_in1, alu_in2, alu_out;
  alu_f_t      alu_sel;

  chip8_alu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .busy(busy), .done(done), .illegal(illegal),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  // Environment: register file with one-cycle read latency.
  logic [7:0] rf [16];
  always @(posedge clk) begin
    rd_data_a <= rf[rd_addr_a];
    rd_data_b <= rf[rd_addr_b];
    if (wr_en) rf[wr_addr] <= wr_data;
  end

  // Environment: combinational 16-bit ALU.
  always_comb begin
    alu_out = 16'h0000;
    case (alu_sel)
      ALU_f_OR:     alu_out = alu_in1 | alu_in2;
      ALU_f_AND:    alu_out = alu_in1 & alu_in2;
      ALU_f_XOR:    alu_out = alu_in1 ^ alu_in2;
      ALU_f_ADD:    alu_out = alu_in1 + alu_in2;
      ALU_f_MINUS:  alu_out = alu_in1 - alu_in2;
      ALU_f_RSHIFT: alu_out = alu_in1 >> alu_in2;
      ALU_f_LSHIFT: alu_out = alu_in1 << alu_in2;
      default:      alu_out = 16'h0000;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model results.
  bit         exp_legal;
  int         exp_lat, exp_nw;
  logic [3:0] exp_wa [2];
  logic [7:0] exp_wd [2];
  logic [7:0] m_rf [16];

  task automatic model(input logic [15:0] op);
    int x, y, n, vx, vy, src, r, f;
    bit has_f;
    x = int'(op[11:8]); y = int'(op[7:4]); n = int'(op[3:0]);
    vx = int'(rf[x]); vy = int'(rf[y]);
`ifdef CHIP8_SHIFT_VY_EN
    src = vy;
`else
    src = vx;
`endif
    for (int i = 0; i < 16; i++) m_rf[i] = rf[i];
    exp_legal = (op[15:12] == 4'h8) && (n <= 7 || n == 14);
    exp_nw = 0;
    exp_lat = 1;
    if (!exp_legal) return;
    has_f = 1; r = 0; f = 0;
    case (n)
      0: begin r = vy; has_f = 0; end
      1: begin r = vx | vy; has_f = 0; end
      2: begin r = vx & vy; has_f = 0; end
      3: begin r = vx ^ vy; has_f = 0; end
      4: begin r = (vx + vy) % 256; f = (vx + vy > 255) ? 1 : 0; end
      5: begin r = (vx - vy + 256) % 256; f = (vx >= vy) ? 1 : 0; end
      7: begin r = (vy - vx + 256) % 256; f = (vy >= vx) ? 1 : 0; end
      6: begin r = src / 2; f = src % 2; end
      default: begin r = (src * 2) % 256; f = src / 128; end
    endcase
    exp_wa[0] = 4'(x);  exp_wd[0] = 8'(r);
    exp_wa[1] = 4'hF;   exp_wd[1] = 8'(f);
    exp_nw  = has_f ? 2 : 1;
    exp_lat = has_f ? 5 : 4;
    m_rf[x] = 8'(r);
    if (has_f) m_rf[15] = 8'(f);
  endtask

  // Issue one opcode (called just after a negedge) and check the whole transaction.
  task automatic run_op(input logic [15:0] op, input bit start_in_done);
    int nw, done_cyc, bad;
    logic [3:0] wa [4];
    logic [7:0] wd [4];
    int wc [4];
    bit ill;
    model(op);
    nw = 0; done_cyc = -1; bad = 0; ill = 0;
    start = 1'b1; opcode = op;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (wr_en) begin
        if (nw < 4) begin wa[nw] = wr_addr; wd[nw] = wr_data; wc[nw] = cyc; end
        nw++;
      end
      if (!busy) bad++;
      if (!(exp_legal && cyc == 2) && (alu_sel != ALU_f_NOP || alu_in1 != 0 || alu_in2 != 0)) bad++;
      if (illegal && !done) bad++;
      if (done) begin
        done_cyc = cyc; ill = illegal;
        start = start_in_done; opcode = 16'($urandom);
        break;
      end
      start = 1'($urandom); opcode = 16'($urandom);
    end
    @(negedge clk);
    check_eq("idle_after_done", {busy, done, wr_en}, 3'b000);
    start = 1'b0;
    check_eq("latency", done_cyc, exp_lat);
    check_eq("illegal", ill, !exp_legal);
    check_eq("write_count", nw, exp_nw);
    for (int i = 0; i < exp_nw && i < nw; i++) begin
      check_eq("wr_addr", wa[i], exp_wa[i]);
      check_eq("wr_data", wd[i], exp_wd[i]);
      check_eq("wr_cycle", wc[i], 3 + i);
    end
    check_eq("busy_alu_protocol", bad, 0);
    for (int i = 0; i < 16; i++) check_eq("reg_file", {i[7:0], rf[i]}, {i[7:0], m_rf[i]});
    $display("op %04h legal=%0d lat=%0d writes=%0d", op, exp_legal, done_cyc, nw);
  endtask

  task automatic rand_rf();
    for (int i = 0; i < 16; i++) rf[i] = 8'($urandom);
  endtask

  initial begin
    int nwr, ndone;
    logic [3:0] n_legal [9];
    logic [15:0] op;
    n_legal[0] = 4'h0; n_legal[1] = 4'h1; n_legal[2] = 4'h2; n_legal[3] = 4'h3;
    n_legal[4] = 4'h4; n_legal[5] = 4'h5; n_legal[6] = 4'h6; n_legal[7] = 4'h7;
    n_legal[8] = 4'hE;
    reset = 1'b1; start = 1'b0; opcode = 16'h0;
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs",
             {busy, done, illegal, wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
              alu_in1, alu_in2, alu_sel}, 59'h0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors.
    rand_rf(); rf[3] = 8'hF0; rf[5] = 8'h20;
    run_op(16'h8354, 1'b0);
    check_eq("v3_8354", rf[3], 8'h10);
    check_eq("vf_8354", rf[15], 8'h01);

    rand_rf(); rf[1] = 8'h05; rf[2] = 8'h07;
    run_op(16'h8125, 1'b1);
    check_eq("v1_8125", {rf[1], rf[15]}, 16'hFE00);
    rf[1] = 8'h07; rf[2] = 8'h05;
    run_op(16'h8127, 1'b0);
    check_eq("v1_8127", {rf[1], rf[15]}, 16'hFE00);

    rand_rf(); rf[4] = 8'h81; rf[6] = 8'h02;
    run_op(16'h846E, 1'b0);
`ifdef CHIP8_SHIFT_VY_EN
    check_eq("v4_846e", {rf[4], rf[15]}, 16'h0400);
`else
    check_eq("v4_846e", {rf[4], rf[15]}, 16'h0201);
`endif

    rand_rf(); rf[15] = 8'hFF; rf[1] = 8'h01;
    run_op(16'h8F14, 1'b1);
    check_eq("vf_8f14", rf[15], 8'h01);

    run_op(16'h8128, 1'b1);
    run_op(16'h7123, 1'b0);

    // Reset in EXEC of 0x8014, with a second start issued while busy.
    rand_rf();
    for (int i = 0; i < 16; i++) m_rf[i] = rf[i];
    start = 1'b1; opcode = 16'h8014;
    @(negedge clk);                       // READ
    start = 1'b1; opcode = 16'h8125;
    @(negedge clk);                       // EXEC
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    check_eq("mid_reset_outputs",
             {busy, done, illegal, wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
              alu_in1, alu_in2, alu_sel}, 59'h0);
    reset = 1'b0;
    nwr = 0; ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wr_en) nwr++;
      if (done || busy) ndone++;
    end
    check_eq("mid_reset_no_writes", nwr, 0);
    check_eq("mid_reset_no_done", ndone, 0);
    for (int i = 0; i < 16; i++) check_eq("mid_reset_rf", {i[7:0], rf[i]}, {i[7:0], m_rf[i]});
    $display("reset-in-EXEC test writes=%0d done/busy cycles=%0d", nwr, ndone);

    // Randomized opcodes.
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 3) != 0) rand_rf();
      if ($urandom_range(0, 9) < 8)
        op = {4'h8, 4'($urandom), 4'($urandom), n_legal[$urandom_range(0, 8)]};
      else
        op = 16'($urandom);
      run_op(op, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
